hdb3_add_b: RTL and testbench



---
 rtl/hdb3_pkg.sv | 18 +
 rtl/hdb3_add_b_if.sv | 24 ++
 rtl/hdb3_dly_line.sv | 29 ++
 rtl/hdb3_add_b.sv | 77 +++++++
 tb/tb_hdb3_add_b.sv | 134 +++++++++++++
 5 files changed

// File: rtl/hdb3_pkg.sv
// Symbol encodings and pipeline depth shared by the HDB3 encoder stages.
package hdb3_pkg;

    typedef logic [1:0] sym_t;

    localparam sym_t SYM_ZERO = 2'b00;
    localparam sym_t SYM_ONE  = 2'b01;
    localparam sym_t SYM_V    = 2'b10;
    localparam sym_t SYM_B    = 2'b11;

    localparam int unsigned HDB3_DLY = 4;

    // B is never legal on the V-stage link; it degrades to a zero.
    function automatic sym_t sanitise(input sym_t s);
        return (s == SYM_B) ? SYM_ZERO : s;
    endfunction

endpackage

// File: rtl/hdb3_add_b_if.sv
// Symbol link between the V-insertion stage and the B-insertion stage.
// b_cnt exists only when HDB3_ADDB_STATS_EN is defined.
interface hdb3_add_b_if;
    import hdb3_pkg::*;

    sym_t        data_addV;
    sym_t        data_addB;
    logic        data_valid;
    logic        sym_err;
`ifdef HDB3_ADDB_STATS_EN
    logic [15:0] b_cnt;

    modport master (output data_addV, input data_addB, input data_valid,
                    input sym_err, input b_cnt);
    modport slave  (input data_addV, output data_addB, output data_valid,
                    output sym_err, output b_cnt);
`else
    modport master (output data_addV, input data_addB, input data_valid,
                    input sym_err);
    modport slave  (input data_addV, output data_addB, output data_valid,
                    output sym_err);
`endif

endinterface

// File: rtl/hdb3_dly_line.sv
// Three-stage symbol shift register (d1..d3) feeding the B-insertion mux.
module hdb3_dly_line
    import hdb3_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  sym_t i_din,
    output sym_t o_d3
);

    sym_t r_d1;
    sym_t r_d2;
    sym_t r_d3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d1 <= SYM_ZERO;
            r_d2 <= SYM_ZERO;
            r_d3 <= SYM_ZERO;
        end else begin
            r_d1 <= i_din;
            r_d2 <= r_d1;
            r_d3 <= r_d2;
        end
    end

    assign o_d3 = r_d3;

endmodule

// File: rtl/hdb3_add_b.sv
// HDB3 B-insertion stage: tracks mark parity since the last V and rewrites the
// first zero of an even-parity group as B. Optional stats: HDB3_ADDB_STATS_EN.
module hdb3_add_b
    import hdb3_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    hdb3_add_b_if.slave  bus
);

    localparam logic [2:0] FILL_FULL = 3'(HDB3_DLY);

    sym_t       w_sym;
    sym_t       w_d3;
    logic       w_illegal;
    logic       w_b_ins;
    logic       w_odd_nxt;

    sym_t       r_d4;
    logic       r_odd;
    logic [2:0] r_fill;
    logic       r_sym_err;

    assign w_illegal = (bus.data_addV == SYM_B);
    assign w_sym     = sanitise(bus.data_addV);

    hdb3_dly_line u_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .i_din   (w_sym),
        .o_d3    (w_d3)
    );

    // d3 holds the first zero of the group when its V is sampled.
    assign w_b_ins = (w_sym == SYM_V) && !r_odd;

    always_comb begin
        w_odd_nxt = r_odd;
        if (w_sym == SYM_ONE)
            w_odd_nxt = ~r_odd;
        else if (w_sym == SYM_V)
            w_odd_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d4      <= SYM_ZERO;
            r_odd     <= 1'b0;
            r_fill    <= '0;
            r_sym_err <= 1'b0;
        end else begin
            r_d4      <= w_b_ins ? SYM_B : w_d3;
            r_odd     <= w_odd_nxt;
            r_sym_err <= w_illegal;
            if (r_fill != FILL_FULL)
                r_fill <= r_fill + 3'd1;
        end
    end

    assign bus.data_addB  = r_d4;
    assign bus.data_valid = (r_fill == FILL_FULL);
    assign bus.sym_err    = r_sym_err;

`ifdef HDB3_ADDB_STATS_EN
    logic [15:0] r_b_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_b_cnt <= '0;
        else if (w_b_ins && (r_b_cnt != '1))
            r_b_cnt <= r_b_cnt + 16'd1;
    end

    assign bus.b_cnt = r_b_cnt;
`endif

endmodule

// File: tb/tb_hdb3_add_b.sv
// Directed and randomized bench for hdb3_add_b against a symbol-history model.
module tb_hdb3_add_b;
    import hdb3_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    hdb3_add_b_if bus ();

    hdb3_add_b dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: sanitised inputs since reset, marks since last V, B count.
    logic [1:0] hist[$];
    int         marks  = 0;
    int         bcnt_m = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_data_addB", 16'(bus.data_addB), 16'h0);
        chk("rst_data_valid", 16'(bus.data_valid), 16'h0);
        chk("rst_sym_err", 16'(bus.sym_err), 16'h0);
`ifdef HDB3_ADDB_STATS_EN
        chk("rst_b_cnt", bus.b_cnt, 16'h0);
`endif
    endtask

    // Reset asserted between edges, checked immediately, released on a falling edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state();
        hist.delete();
        marks  = 0;
        bcnt_m = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic step(input logic [1:0] s);
        logic [1:0] clean;
        logic [1:0] exp_out;
        int         e;
        bus.data_addV = s;
        @(posedge clk);
        #1;
        clean = (s == 2'b11) ? 2'b00 : s;
        hist.push_back(clean);
        e = hist.size();
        if (clean == 2'b10 && (marks % 2) == 0) begin
            exp_out = 2'b11;
            if (bcnt_m < 65535) bcnt_m++;
        end else if (e >= 4) begin
            exp_out = hist[e-4];
        end else begin
            exp_out = 2'b00;
        end
        if (clean == 2'b01) marks++;
        else if (clean == 2'b10) marks = 0;
        chk("data_addB", 16'(bus.data_addB), 16'(exp_out));
        chk("data_valid", 16'(bus.data_valid), (e >= 4) ? 16'h1 : 16'h0);
        chk("sym_err", 16'(bus.sym_err), (s == 2'b11) ? 16'h1 : 16'h0);
`ifdef HDB3_ADDB_STATS_EN
        chk("b_cnt", bus.b_cnt, 16'(bcnt_m));
`endif
    endtask

    initial begin
        int r;
        bus.data_addV = 2'b00;
        #3;
        check_reset_state();
        @(negedge clk);
        reset_n = 1'b1;

        // Even parity at reset: B on first zero.
        step(2'b00); step(2'b00); step(2'b00); step(2'b10);
        step(2'b00); step(2'b00); step(2'b00);
        // Odd parity: no B.
        step(2'b01); step(2'b00); step(2'b00); step(2'b00); step(2'b10);
        // Back-to-back group after an odd-parity V: B inserted.
        step(2'b00); step(2'b00); step(2'b00); step(2'b10);
        // Two marks then a group.
        step(2'b01); step(2'b01); step(2'b00); step(2'b00); step(2'b00); step(2'b10);
        step(2'b00); step(2'b00); step(2'b00);
        // Illegal symbol does not change parity.
        step(2'b01); step(2'b11); step(2'b00); step(2'b00); step(2'b00); step(2'b10);
        step(2'b00); step(2'b00); step(2'b00);

        // Mid-group reset, then a fresh group gets B.
        step(2'b01); step(2'b00); step(2'b00);
        do_reset();
        step(2'b00); step(2'b00); step(2'b00); step(2'b10);
        step(2'b00); step(2'b00); step(2'b00);

        // Random legal-ish traffic with occasional illegal symbols and resets.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                for (int k = 0; k < 3; k++)
                    step(($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00);
                step(2'b10);
            end else if (r < 6) begin
                step(2'b01);
            end else if (r == 6) begin
                step(2'b11);
            end else begin
                step(2'b00);
            end
            if ($urandom_range(0, 149) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
